// File: rtl/crosswalk_scheduler_if.sv
// crosswalk_scheduler_if: traffic-hold handshake between crosswalk scheduler and intersection
interface crosswalk_scheduler_if;
  logic hold_req;
  logic hold_sel;
  logic hold_ack;
  modport master (output hold_req, output hold_sel, input hold_ack);
  modport slave (input hold_req, input hold_sel, output hold_ack);
endinterface

// File: rtl/crosswalk_scheduler.sv
// crosswalk_scheduler: round-robin pedestrian crossing sequencer for two crosswalks
module crosswalk_scheduler #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int WALK_TICKS  = 10,
  parameter int FLASH_TICKS = 6,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_req_0,
  input  logic ped_req_1,
  crosswalk_scheduler_if.master hs,
  output logic walk_0,
  output logic walk_1,
  output logic dont_walk_0,
  output logic dont_walk_1,
  output logic [1:0] pending,
  output logic abort
);
  typedef enum logic [2:0] {IDLE, REQ, WALK, FLASH, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync1_q, sync2_q, prev_q, pending_q, pending_d;
  logic [1:0] rise, sel_m, drop, clr;
  logic sel_q, sel_d, last_q, last_d, abort_q, abort_d;
  logic [CNT_W-1:0] pre_q, pre_d, tmr_q, tmr_d;
  logic tick, done, dw_on, lit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      abort_q   <= 1'b0;
      pre_q     <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= {ped_req_1, ped_req_0};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      pre_q     <= pre_d;
      tmr_q     <= tmr_d;
    end
  end
  always_comb begin
    rise      = sync2_q & ~prev_q;
    sel_m     = sel_q ? 2'b10 : 2'b01;
    tick      = pre_q == CNT_W'(TICK_DIV - 1);
    done      = tick && tmr_q == CNT_W'(1);
    drop      = state_q == WALK ? sel_m : 2'b00;
    clr       = (state_q == REQ && hs.hold_ack) ? sel_m : 2'b00;
    pending_d = (pending_q | (rise & ~drop)) & ~clr;
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    abort_d   = 1'b0;
    pre_d     = pre_q;
    tmr_d     = tmr_q;
    case (state_q)
      IDLE: if (|pending_q) begin
        sel_d   = &pending_q ? ~last_q : pending_q[1];
        state_d = REQ;
      end
      REQ: if (hs.hold_ack) begin
        state_d = WALK;
        pre_d   = '0;
        tmr_d   = CNT_W'(WALK_TICKS);
      end
      WALK, FLASH: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        tmr_d = tmr_q - CNT_W'(tick);
        if (!hs.hold_ack) begin
          abort_d = 1'b1;
          state_d = RELEASE;
        end else if (done) begin
          state_d = state_q == WALK ? FLASH : RELEASE;
          tmr_d   = CNT_W'(FLASH_TICKS);
        end
      end
      RELEASE: if (!hs.hold_ack) begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dw_on       = tmr_q[0] == 1'(FLASH_TICKS % 2);
    lit         = state_q == WALK || (state_q == FLASH && !dw_on);
    walk_0      = state_q == WALK && !sel_q;
    walk_1      = state_q == WALK && sel_q;
    dont_walk_0 = !(lit && !sel_q);
    dont_walk_1 = !(lit && sel_q);
    pending     = pending_q;
    abort       = abort_q;
  end
  assign hs.hold_req = state_q == REQ || state_q == WALK || state_q == FLASH;
  assign hs.hold_sel = sel_q;
endmodule

// File: tb/tb_crosswalk_scheduler.sv
// tb_crosswalk_scheduler: directed and random checks against a cycle-count reference model
module tb_crosswalk_scheduler;
  localparam int DIV = 4, WT = 3, FT = 2;
  logic clk = 1'b0, reset = 1'b1, p0 = 1'b0, p1 = 1'b0;
  logic walk_0, walk_1, dont_walk_0, dont_walk_1, abort;
  logic [1:0] pending;
  crosswalk_scheduler_if hs ();
  crosswalk_scheduler #(.TICK_DIV(DIV), .WALK_TICKS(WT), .FLASH_TICKS(FT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ped_req_0(p0), .ped_req_1(p1), .hs(hs),
    .walk_0(walk_0), .walk_1(walk_1), .dont_walk_0(dont_walk_0), .dont_walk_1(dont_walk_1),
    .pending(pending), .abort(abort)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_phase, m_el, cnt, ack_dly = 5, drop_dly = 2;
  bit m_sel, m_last, m_abort, kill, no_ack, rnd;
  bit [1:0] m_pend, h0, h1, h2;
  function automatic logic [8:0] obs();
    return {hs.hold_req, hs.hold_sel, walk_1, walk_0, dont_walk_1, dont_walk_0, pending, abort};
  endfunction
  function automatic logic [8:0] expv();
    bit w, dws;
    w   = m_phase == 2;
    dws = !(w || (m_phase == 3 && ((m_el / DIV) % 2) == 1));
    return {m_phase >= 1 && m_phase <= 3, m_sel, w && m_sel, w && !m_sel,
            m_sel ? dws : 1'b1, m_sel ? 1'b1 : dws, m_pend, m_abort};
  endfunction
  task automatic model_edge();
    bit [1:0] rise, drop, clr, mask;
    if (reset) begin
      m_phase = 0; m_el = 0; m_sel = 0; m_last = 1; m_pend = 0; m_abort = 0;
      h0 = 0; h1 = 0; h2 = 0;
      return;
    end
    rise = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = {p1, p0};
    mask = m_sel ? 2'b10 : 2'b01;
    drop = m_phase == 2 ? mask : 2'b00;
    clr = 2'b00;
    m_abort = 0;
    case (m_phase)
      0: if (m_pend != 0) begin
        m_sel = (m_pend == 2'b11) ? !m_last : m_pend[1];
        m_phase = 1;
      end
      1: if (hs.hold_ack) begin
        clr = mask; m_phase = 2; m_el = 0;
      end
      2, 3: if (!hs.hold_ack) begin
        m_abort = 1; m_phase = 4;
      end else if (m_el + 1 == (m_phase == 2 ? WT : FT) * DIV) begin
        m_phase = m_phase + 1; m_el = 0;
      end else m_el++;
      4: if (!hs.hold_ack) begin
        m_last = m_sel; m_phase = 0;
      end
      default: m_phase = 0;
    endcase
    m_pend = (m_pend | (rise & ~drop)) & ~clr;
  endtask
  task automatic step(input string tag);
    if (kill) begin
      hs.hold_ack = 1'b0; kill = 0; cnt = 0;
    end else if (hs.hold_req && !hs.hold_ack) begin
      cnt++;
      if (!no_ack && cnt >= ack_dly) begin hs.hold_ack = 1'b1; cnt = 0; end
    end else if (!hs.hold_req && hs.hold_ack) begin
      cnt++;
      if (cnt >= drop_dly) begin hs.hold_ack = 1'b0; cnt = 0; end
    end else cnt = 0;
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    assert (obs() === expv()) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs(), expv());
    end
  endtask
  task automatic press(input bit a, input bit b, input string tag);
    p0 = a; p1 = b;
    step(tag);
    p0 = 0; p1 = 0;
  endtask
  task automatic wait_walk(input bit which, input int lim, input string tag);
    int n = 0;
    while ((which ? walk_1 : walk_0) !== 1'b1 && n < lim) begin step(tag); n++; end
    checks++;
    assert ((which ? walk_1 : walk_0) === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=0 expected=1", tag);
    end
  endtask
  task automatic do_reset(input string tag);
    reset = 1; hs.hold_ack = 1'b0; cnt = 0; kill = 0;
    step(tag);
    reset = 0;
    checks++;
    assert (obs() === 9'b0000_1100_0) else begin
      errors++;
      $error("FAIL %s_vals observed=%b expected=%b", tag, obs(), 9'b000011000);
    end
  endtask
  initial begin
    int wcnt, dcnt, nserv;
    bit [1:0] order;
    bit prev;
    hs.hold_ack = 1'b0;
    do_reset("reset");
    do_reset("reset2");
    press(1, 0, "t1_press");
    wcnt = 0; dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      step("t1");
      wcnt += int'(walk_0);
      dcnt += int'(!dont_walk_0);
    end
    checks++;
    assert (wcnt == WT * DIV && dcnt == WT * DIV + DIV) else begin
      errors++;
      $error("FAIL t1_lens observed=%0d/%0d expected=%0d/%0d", wcnt, dcnt, WT * DIV, WT * DIV + DIV);
    end
    do_reset("t2_reset");
    press(1, 1, "t2_press");
    order = 0; nserv = 0; prev = 0;
    for (int i = 0; i < 100; i++) begin
      step("t2");
      if (hs.hold_req && !prev) begin order = {order[0], hs.hold_sel}; nserv++; end
      prev = hs.hold_req;
    end
    checks++;
    assert (order == 2'b01 && nserv == 2) else begin
      errors++;
      $error("FAIL t2_order observed=%b/%0d expected=01/2", order, nserv);
    end
    press(1, 0, "t3_press");
    wait_walk(0, 40, "t3_wait");
    for (int i = 0; i < 4; i++) step("t3_walk");
    kill = 1;
    step("t3_abort");
    checks++;
    assert ({abort, walk_0, dont_walk_0, hs.hold_req} === 4'b1010) else begin
      errors++;
      $error("FAIL t3_abort observed=%b expected=1010", {abort, walk_0, dont_walk_0, hs.hold_req});
    end
    step("t3_after");
    checks++;
    assert (abort === 1'b0) else begin
      errors++;
      $error("FAIL t3_pulse observed=%b expected=0", abort);
    end
    for (int i = 0; i < 10; i++) step("t3_idle");
    press(0, 1, "t4_press");
    wait_walk(1, 40, "t4_wait");
    for (int i = 0; i < WT * DIV + 2; i++) step("t4_flash");
    do_reset("t4_reset");
    press(1, 0, "t4_req");
    for (int i = 0; i < 45; i++) step("t4_serve");
    press(1, 0, "t5_press");
    wait_walk(0, 40, "t5_wait");
    step("t5_walk");
    press(1, 0, "t5_walkpress");
    for (int i = 0; i < 4; i++) step("t5_drop");
    checks++;
    assert (pending === 2'b00 && walk_0 === 1'b1) else begin
      errors++;
      $error("FAIL t5_drop observed=%b/%b expected=00/1", pending, walk_0);
    end
    for (int i = 0; i < 7; i++) step("t5_toflash");
    press(1, 0, "t5_flashpress");
    for (int i = 0; i < 3; i++) step("t5_latch");
    checks++;
    assert (pending === 2'b01) else begin
      errors++;
      $error("FAIL t5_latch observed=%b expected=01", pending);
    end
    wait_walk(0, 40, "t5_second");
    for (int i = 0; i < 30; i++) step("t5_done");
    no_ack = 1;
    press(1, 0, "t6_press");
    for (int i = 0; i < 100; i++) step("t6_wait");
    checks++;
    assert ({hs.hold_req, hs.hold_sel, walk_0} === 3'b100) else begin
      errors++;
      $error("FAIL t6_noack observed=%b expected=100", {hs.hold_req, hs.hold_sel, walk_0});
    end
    no_ack = 0;
    for (int i = 0; i < 45; i++) step("t6_serve");
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      p0 = ($urandom_range(0, 11) == 0);
      p1 = ($urandom_range(0, 11) == 0);
      if (cnt == 0) begin ack_dly = $urandom_range(1, 8); drop_dly = $urandom_range(1, 4); end
      if (hs.hold_req && hs.hold_ack && $urandom_range(0, 149) == 0) kill = 1;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1; hs.hold_ack = 1'b0; cnt = 0; kill = 0;
      end
      step("random");
      reset = 0;
    end
    p0 = 0; p1 = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
